hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard_pkg.sv | 12 +
 rtl/hazard_scoreboard_md_tracker.sv | 62 ++++++
 rtl/hazard_scoreboard.sv | 75 +++++++
 tb/tb_hazard_scoreboard.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the hazard scoreboard: forwarding mux selects and result-source codes.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_WB   = 2'b01,
    FWD_MEM  = 2'b10
  } fwd_e;

  localparam logic [1:0] RESSRC_LOAD = 2'b01;

endpackage

// File: rtl/hazard_scoreboard_md_tracker.sv
// Tracks the single in-flight multicycle op; mdDone is combinational, MD_LAT-1 cycles after issue.
// Issue is refused while busy, including on the mdDone cycle.
module md_tracker
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 8,
  parameter int CNT_W  = $clog2(MD_LAT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mdStartE,
  input  logic [REG_AW-1:0] rdE,
  output logic              mdBusy,
  output logic              mdDone,
  output logic [REG_AW-1:0] mdRd
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LAT - 2);

  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [REG_AW-1:0] rd_q, rd_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rd_q   <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
    end
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rd_d   = rd_q;
    if (!busy_q) begin
      if (mdStartE) begin
        busy_d = 1'b1;
        cnt_d  = CNT_LOAD;
        rd_d   = rdE;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  assign mdBusy = busy_q;
  assign mdDone = busy_q && (cnt_q == '0);
  assign mdRd   = rd_q;

  // A second issue while occupied is dropped; upstream stalls should make this unreachable.
  start_while_busy: assert property (@(posedge clk) disable iff (!rst_n) !(mdStartE && busy_q))
    else $error("mdStartE ignored while multicycle unit busy");

endmodule

// File: rtl/hazard_scoreboard.sv
// Forwarding selects and stall/flush controls for a 5-stage pipeline with one multicycle unit.
// Purely combinational except the multicycle tracker; stalls hold F/D and bubble E.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 8,
  parameter int CNT_W  = $clog2(MD_LAT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs1D,
  input  logic [REG_AW-1:0] rs2D,
  input  logic [REG_AW-1:0] rdD,
  input  logic              regWriteD,
  input  logic              mdOpD,
  input  logic [REG_AW-1:0] rs1E,
  input  logic [REG_AW-1:0] rs2E,
  input  logic [REG_AW-1:0] rdE,
  input  logic              regWriteE,
  input  logic              mdStartE,
  input  logic [1:0]        resultSrcE,
  input  logic [REG_AW-1:0] rdM,
  input  logic              regWriteM,
  input  logic [REG_AW-1:0] rdW,
  input  logic              regWriteW,
  input  logic              pcSrcE,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              stallF,
  output logic              stallD,
  output logic              flushD,
  output logic              flushE,
  output logic              mdBusy,
  output logic              mdDone,
  output logic [REG_AW-1:0] mdRd
);

  logic lwStall, mdStall, mdRaw, mdWaw;

  md_tracker #(.REG_AW(REG_AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) u_md_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .mdStartE (mdStartE),
    .rdE      (rdE),
    .mdBusy   (mdBusy),
    .mdDone   (mdDone),
    .mdRd     (mdRd)
  );

  // M is the younger producer, so it wins over W.
  always_comb begin
    forwardAE = FWD_NONE;
    if (regWriteM && (rs1E == rdM) && (rs1E != '0))      forwardAE = FWD_MEM;
    else if (regWriteW && (rs1E == rdW) && (rs1E != '0)) forwardAE = FWD_WB;

    forwardBE = FWD_NONE;
    if (regWriteM && (rs2E == rdM) && (rs2E != '0))      forwardBE = FWD_MEM;
    else if (regWriteW && (rs2E == rdW) && (rs2E != '0)) forwardBE = FWD_WB;
  end

  assign lwStall = (resultSrcE == RESSRC_LOAD) && regWriteE && (rdE != '0) &&
                   ((rdE == rs1D) || (rdE == rs2D));

  // Only the x0 source match is suppressed; WAW and structural checks still see mdRd==0.
  assign mdRaw   = (mdRd != '0) && ((mdRd == rs1D) || (mdRd == rs2D));
  assign mdWaw   = regWriteD && (rdD == mdRd);
  assign mdStall = mdBusy && !mdDone && (mdRaw || mdWaw || mdOpD);

  assign stallF = lwStall | mdStall;
  assign stallD = lwStall | mdStall;
  assign flushD = pcSrcE;
  assign flushE = lwStall | mdStall | pcSrcE;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized and directed checks of hazard_scoreboard at two multicycle latencies against an issue-time model.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int AW = 5;
  localparam int LAT [2] = '{4, 8};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [AW-1:0] rs1D, rs2D, rdD, rs1E, rs2E, rdE, rdM, rdW;
  logic          regWriteD, mdOpD, regWriteE, mdStartE, regWriteM, regWriteW, pcSrcE;
  logic [1:0]    resultSrcE;

  logic [1:0]    fA [2];
  logic [1:0]    fB [2];
  logic          sF [2];
  logic          sD [2];
  logic          fD [2];
  logic          fE [2];
  logic          bsy [2];
  logic          dn [2];
  logic [AW-1:0] rdo [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    hazard_scoreboard #(.REG_AW(AW), .MD_LAT(LAT[g])) dut (
      .clk(clk), .rst_n(rst_n),
      .rs1D(rs1D), .rs2D(rs2D), .rdD(rdD), .regWriteD(regWriteD), .mdOpD(mdOpD),
      .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE), .regWriteE(regWriteE), .mdStartE(mdStartE),
      .resultSrcE(resultSrcE), .rdM(rdM), .regWriteM(regWriteM), .rdW(rdW),
      .regWriteW(regWriteW), .pcSrcE(pcSrcE),
      .forwardAE(fA[g]), .forwardBE(fB[g]), .stallF(sF[g]), .stallD(sD[g]),
      .flushD(fD[g]), .flushE(fE[g]), .mdBusy(bsy[g]), .mdDone(dn[g]), .mdRd(rdo[g])
    );
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model: an op issued in cycle iss occupies cycles iss+1 .. iss+LAT-1 and completes in the last one.
  bit            issued [2];
  int            iss [2];
  logic [AW-1:0] mrd [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit m_busy(input int k);
    return rst_n && issued[k] && (cyc >= iss[k] + 1) && (cyc <= iss[k] + LAT[k] - 1);
  endfunction

  function automatic bit m_done(input int k);
    return rst_n && issued[k] && (cyc == iss[k] + LAT[k] - 1);
  endfunction

  function automatic logic [1:0] exp_fwd(input logic [AW-1:0] rs);
    if (rs != 0 && regWriteM && rs == rdM) return 2'b10;
    if (rs != 0 && regWriteW && rs == rdW) return 2'b01;
    return 2'b00;
  endfunction

  task automatic eval();
    bit lw, ms;
    #1;
    if (!rst_n)
      for (int k = 0; k < 2; k++) begin
        issued[k] = 1'b0;
        mrd[k]    = '0;
      end
    lw = (resultSrcE == 2'b01) && regWriteE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
    for (int k = 0; k < 2; k++) begin
      ms = m_busy(k) && !m_done(k) &&
           ((mrd[k] != 0 && (mrd[k] == rs1D || mrd[k] == rs2D)) ||
            (regWriteD && rdD == mrd[k]) || mdOpD);
      check($sformatf("fwdA%0d", k),   fA[k],  exp_fwd(rs1E));
      check($sformatf("fwdB%0d", k),   fB[k],  exp_fwd(rs2E));
      check($sformatf("stallF%0d", k), sF[k],  lw | ms);
      check($sformatf("stallD%0d", k), sD[k],  lw | ms);
      check($sformatf("flushD%0d", k), fD[k],  pcSrcE);
      check($sformatf("flushE%0d", k), fE[k],  lw | ms | pcSrcE);
      check($sformatf("busy%0d", k),   bsy[k], m_busy(k));
      check($sformatf("done%0d", k),   dn[k],  m_done(k));
      check($sformatf("mdRd%0d", k),   rdo[k], mrd[k]);
    end
  endtask

  task automatic tick();
    bit b;
    @(posedge clk);
    for (int k = 0; k < 2; k++)
      if (rst_n) begin
        b = m_busy(k);
        if (mdStartE && !b) begin
          issued[k] = 1'b1;
          iss[k]    = cyc;
          mrd[k]    = rdE;
        end else if (m_done(k)) begin
          issued[k] = 1'b0;
        end
      end
    cyc++;
    #1;
  endtask

  task automatic clear_inputs();
    {rs1D, rs2D, rdD, rs1E, rs2E, rdE, rdM, rdW} = '0;
    {regWriteD, mdOpD, regWriteE, mdStartE, regWriteM, regWriteW, pcSrcE} = '0;
    resultSrcE = 2'b00;
  endtask

  initial begin
    issued = '{0, 0};
    iss    = '{0, 0};
    mrd    = '{'0, '0};
    rst_n  = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    eval();
    tick();

    // Issue on the very first edge after reset release, RAW source held in D.
    rst_n = 1'b1; mdStartE = 1'b1; rdE = 9; rs1D = 9;
    eval(); check("raw_c0_stall", sD[0], 1'b0);
    tick();
    mdStartE = 1'b0; rdE = 0; pcSrcE = 1'b1;
    eval(); check("raw_c1_stall", sD[0], 1'b1);
    check("br_flushD", fD[0], 1'b1); check("br_flushE", fE[0], 1'b1);
    tick();
    pcSrcE = 1'b0;
    eval(); check("raw_c2_stall", sD[0], 1'b1);
    tick();
    eval(); check("raw_c3_done", dn[0], 1'b1); check("raw_c3_nostall", sD[0], 1'b0);
    tick();
    eval(); check("raw_c4_idle", bsy[0], 1'b0);
    for (int c = 5; c <= 8; c++) begin
      tick();
      eval();
      if (c == 7) check("lat8_done", dn[1], 1'b1);
    end
    tick();
    rs1D = 0;

    // Forwarding priority and x0 suppression.
    rs1E = 5; rdM = 5; regWriteM = 1; rdW = 5; regWriteW = 1;
    eval(); check("fwd_mem", fA[0], 2'b10);
    rs1E = 0;
    eval(); check("fwd_x0", fA[0], 2'b00);
    tick();
    clear_inputs();

    // Load-use.
    resultSrcE = 2'b01; rdE = 7; regWriteE = 1; rs2D = 7;
    eval();
    check("lu_stallF", sF[0], 1'b1); check("lu_stallD", sD[0], 1'b1);
    check("lu_flushE", fE[0], 1'b1); check("lu_flushD", fD[0], 1'b0);
    tick();
    clear_inputs();
    eval(); tick();

    // Structural, WAW, then an unrelated destination.
    mdStartE = 1; rdE = 3;
    eval(); tick();
    clear_inputs(); mdOpD = 1;
    eval(); check("struct_stall", sD[0], 1'b1);
    tick();
    mdOpD = 0; regWriteD = 1; rdD = 3;
    eval(); check("waw_stall", sD[0], 1'b1);
    tick();
    rdD = 4;
    eval(); check("nomatch_nostall", sD[1], 1'b0);
    for (int c = 0; c < 6; c++) begin tick(); eval(); end
    tick();
    clear_inputs();

    // Reset in cycle 2 of an 8-cycle op.
    mdStartE = 1; rdE = 12;
    eval(); tick();
    mdStartE = 0;
    eval(); tick();
    rst_n = 1'b0;
    eval(); check("rst_busy", bsy[1], 1'b0); check("rst_rd", rdo[1], 0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      eval(); check("rst_nodone", dn[1], 1'b0);
      tick();
    end

    // Random traffic; issue only when both units are idle.
    for (int n = 0; n < 600; n++) begin
      rst_n      = ($urandom_range(0, 59) != 0);
      rs1D       = AW'($urandom_range(0, 3));
      rs2D       = AW'($urandom_range(0, 3));
      rdD        = AW'($urandom_range(0, 3));
      rs1E       = AW'($urandom_range(0, 3));
      rs2E       = AW'($urandom_range(0, 3));
      rdE        = AW'($urandom_range(0, 3));
      rdM        = AW'($urandom_range(0, 3));
      rdW        = AW'($urandom_range(0, 3));
      regWriteD  = $urandom_range(0, 1) == 1;
      mdOpD      = $urandom_range(0, 3) == 0;
      regWriteE  = $urandom_range(0, 1) == 1;
      regWriteM  = $urandom_range(0, 1) == 1;
      regWriteW  = $urandom_range(0, 1) == 1;
      pcSrcE     = $urandom_range(0, 4) == 0;
      resultSrcE = 2'($urandom_range(0, 3));
      mdStartE   = !m_busy(0) && !m_busy(1) && ($urandom_range(0, 2) == 0);
      eval();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
